// File: rtl/cdb_arbiter_if.sv
// Result-bus bundle between the ALU/LSB producers and the CDB arbiter.
// Producers push with *_en and watch *_full; the CDB fields are the registered broadcast.
interface cdb_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
);
  logic                  rdy_in;
  logic                  flush_in;

  logic                  ALU2ARB_en;
  logic [ROB_WIDTH-1:0]  ALU2ARB_ROB_index;
  logic [31:0]           ALU2ARB_value;
  logic [ADDR_WIDTH-1:0] ALU2ARB_next_pc;
  logic                  ARB2ALU_full;

  logic                  LSB2ARB_en;
  logic [ROB_WIDTH-1:0]  LSB2ARB_ROB_index;
  logic [31:0]           LSB2ARB_value;
  logic                  ARB2LSB_full;

  logic                  CDB_en;
  logic [ROB_WIDTH-1:0]  CDB_ROB_index;
  logic [31:0]           CDB_value;
  logic [ADDR_WIDTH-1:0] CDB_next_pc;
  logic                  CDB_src;

  modport slave (
    input  rdy_in, flush_in,
    input  ALU2ARB_en, ALU2ARB_ROB_index, ALU2ARB_value, ALU2ARB_next_pc,
    output ARB2ALU_full,
    input  LSB2ARB_en, LSB2ARB_ROB_index, LSB2ARB_value,
    output ARB2LSB_full,
    output CDB_en, CDB_ROB_index, CDB_value, CDB_next_pc, CDB_src
  );

  modport master (
    output rdy_in, flush_in,
    output ALU2ARB_en, ALU2ARB_ROB_index, ALU2ARB_value, ALU2ARB_next_pc,
    input  ARB2ALU_full,
    output LSB2ARB_en, LSB2ARB_ROB_index, LSB2ARB_value,
    input  ARB2LSB_full,
    input  CDB_en, CDB_ROB_index, CDB_value, CDB_next_pc, CDB_src
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over two small result FIFOs (ALU, LSB); push->broadcast is 2 edges.
// Backpressure via *_full (count == depth); rdy_in low freezes everything, flush drops all pending.
module cdb_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int ROB_WIDTH   = 4,
  parameter int DEPTH_WIDTH = 1
) (
  input  logic           clk_in,
  input  logic           rst_n_in,
  cdb_arbiter_if.slave   bus
);
  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam logic [DEPTH_WIDTH:0] DEPTH_CNT = (DEPTH_WIDTH+1)'(DEPTH);

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  tag;
    logic [31:0]           value;
    logic [ADDR_WIDTH-1:0] next_pc;
  } alu_ent_t;

  typedef struct packed {
    logic [ROB_WIDTH-1:0]  tag;
    logic [31:0]           value;
  } lsb_ent_t;

  alu_ent_t               alu_mem_q [DEPTH];
  alu_ent_t               alu_mem_d [DEPTH];
  lsb_ent_t               lsb_mem_q [DEPTH];
  lsb_ent_t               lsb_mem_d [DEPTH];
  logic [DEPTH_WIDTH-1:0] alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [DEPTH_WIDTH-1:0] lsb_wr_q, lsb_wr_d, lsb_rd_q, lsb_rd_d;
  logic [DEPTH_WIDTH:0]   alu_cnt_q, alu_cnt_d, lsb_cnt_q, lsb_cnt_d;
  logic                   last_lsb_q, last_lsb_d;

  logic                   cdb_en_q, cdb_en_d;
  logic [ROB_WIDTH-1:0]   cdb_tag_q, cdb_tag_d;
  logic [31:0]            cdb_value_q, cdb_value_d;
  logic [ADDR_WIDTH-1:0]  cdb_pc_q, cdb_pc_d;
  logic                   cdb_src_q, cdb_src_d;

  logic     alu_full, lsb_full, alu_ne, lsb_ne;
  logic     gnt_alu, gnt_lsb, advance, do_flush;
  logic     alu_push, lsb_push, alu_pop, lsb_pop;
  alu_ent_t alu_head;
  lsb_ent_t lsb_head;

  assign alu_full = (alu_cnt_q == DEPTH_CNT);
  assign lsb_full = (lsb_cnt_q == DEPTH_CNT);
  assign alu_ne   = (alu_cnt_q != '0);
  assign lsb_ne   = (lsb_cnt_q != '0);
  assign alu_head = alu_mem_q[alu_rd_q];
  assign lsb_head = lsb_mem_q[lsb_rd_q];

  // Ties go to whichever source did not win last; last_lsb_q resets high so ALU wins first.
  assign gnt_alu  = alu_ne && (!lsb_ne || last_lsb_q);
  assign gnt_lsb  = lsb_ne && !gnt_alu;

  assign do_flush = bus.rdy_in && bus.flush_in;
  assign advance  = bus.rdy_in && !bus.flush_in;
  // Full refuses a push even when the same edge pops; keeps the full path off the grant logic.
  assign alu_push = advance && bus.ALU2ARB_en && !alu_full;
  assign lsb_push = advance && bus.LSB2ARB_en && !lsb_full;
  assign alu_pop  = advance && gnt_alu;
  assign lsb_pop  = advance && gnt_lsb;

  always_comb begin
    alu_mem_d = alu_mem_q;
    lsb_mem_d = lsb_mem_q;
    alu_wr_d  = alu_wr_q;
    alu_rd_d  = alu_rd_q;
    lsb_wr_d  = lsb_wr_q;
    lsb_rd_d  = lsb_rd_q;
    alu_cnt_d = alu_cnt_q;
    lsb_cnt_d = lsb_cnt_q;
    if (do_flush) begin
      alu_wr_d  = '0;
      alu_rd_d  = '0;
      lsb_wr_d  = '0;
      lsb_rd_d  = '0;
      alu_cnt_d = '0;
      lsb_cnt_d = '0;
    end else begin
      if (alu_push) begin
        alu_mem_d[alu_wr_q] = '{tag: bus.ALU2ARB_ROB_index, value: bus.ALU2ARB_value,
                                next_pc: bus.ALU2ARB_next_pc};
        alu_wr_d = alu_wr_q + DEPTH_WIDTH'(1);
      end
      if (lsb_push) begin
        lsb_mem_d[lsb_wr_q] = '{tag: bus.LSB2ARB_ROB_index, value: bus.LSB2ARB_value};
        lsb_wr_d = lsb_wr_q + DEPTH_WIDTH'(1);
      end
      if (alu_pop) alu_rd_d = alu_rd_q + DEPTH_WIDTH'(1);
      if (lsb_pop) lsb_rd_d = lsb_rd_q + DEPTH_WIDTH'(1);
      alu_cnt_d = alu_cnt_q + (DEPTH_WIDTH+1)'(alu_push) - (DEPTH_WIDTH+1)'(alu_pop);
      lsb_cnt_d = lsb_cnt_q + (DEPTH_WIDTH+1)'(lsb_push) - (DEPTH_WIDTH+1)'(lsb_pop);
    end
  end

  always_comb begin
    cdb_en_d    = cdb_en_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_value_d = cdb_value_q;
    cdb_pc_d    = cdb_pc_q;
    cdb_src_d   = cdb_src_q;
    last_lsb_d  = last_lsb_q;
    if (do_flush) begin
      cdb_en_d   = 1'b0;
      last_lsb_d = 1'b1;
    end else if (alu_pop) begin
      cdb_en_d    = 1'b1;
      cdb_tag_d   = alu_head.tag;
      cdb_value_d = alu_head.value;
      cdb_pc_d    = alu_head.next_pc;
      cdb_src_d   = 1'b0;
      last_lsb_d  = 1'b0;
    end else if (lsb_pop) begin
      cdb_en_d    = 1'b1;
      cdb_tag_d   = lsb_head.tag;
      cdb_value_d = lsb_head.value;
      cdb_pc_d    = '0;
      cdb_src_d   = 1'b1;
      last_lsb_d  = 1'b1;
    end else if (bus.rdy_in) begin
      cdb_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      alu_mem_q   <= '{default: '0};
      lsb_mem_q   <= '{default: '0};
      alu_wr_q    <= '0;
      alu_rd_q    <= '0;
      lsb_wr_q    <= '0;
      lsb_rd_q    <= '0;
      alu_cnt_q   <= '0;
      lsb_cnt_q   <= '0;
      last_lsb_q  <= 1'b1;
      cdb_en_q    <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_value_q <= '0;
      cdb_pc_q    <= '0;
      cdb_src_q   <= 1'b0;
    end else begin
      alu_mem_q   <= alu_mem_d;
      lsb_mem_q   <= lsb_mem_d;
      alu_wr_q    <= alu_wr_d;
      alu_rd_q    <= alu_rd_d;
      lsb_wr_q    <= lsb_wr_d;
      lsb_rd_q    <= lsb_rd_d;
      alu_cnt_q   <= alu_cnt_d;
      lsb_cnt_q   <= lsb_cnt_d;
      last_lsb_q  <= last_lsb_d;
      cdb_en_q    <= cdb_en_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_value_q <= cdb_value_d;
      cdb_pc_q    <= cdb_pc_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign bus.ARB2ALU_full  = alu_full;
  assign bus.ARB2LSB_full  = lsb_full;
  assign bus.CDB_en        = cdb_en_q;
  assign bus.CDB_ROB_index = cdb_tag_q;
  assign bus.CDB_value     = cdb_value_q;
  assign bus.CDB_next_pc   = cdb_pc_q;
  assign bus.CDB_src       = cdb_src_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboarded bench for cdb_arbiter: stimulus queues expected broadcasts, a negedge monitor
// pops and compares each CDB pulse, directed checks cover full, flush, freeze and async reset.
module tb_cdb_arbiter;
  localparam int AW = 32;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.ADDR_WIDTH(AW), .ROB_WIDTH(RW)) bif ();

  cdb_arbiter #(.ADDR_WIDTH(AW), .ROB_WIDTH(RW), .DEPTH_WIDTH(1)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .bus      (bif)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] value;
    logic [31:0] pc;
    logic        src;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic rdy_at_edge = 1'b0;

  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rdy_at_edge <= bif.rdy_in;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // A broadcast is consumed only when the edge that produced it was not frozen.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && rdy_at_edge && bif.CDB_en) begin
      if (exp_q.size() == 0) begin
        chk("cdb_spurious_en", bif.CDB_en, 0);
      end else begin
        e = exp_q.pop_front();
        chk("cdb_tag",   bif.CDB_ROB_index, e.tag);
        chk("cdb_value", bif.CDB_value,     e.value);
        chk("cdb_pc",    bif.CDB_next_pc,   e.pc);
        chk("cdb_src",   bif.CDB_src,       e.src);
        if (e.due >= 0) chk("cdb_latency", cyc, e.due);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_en();
    bif.ALU2ARB_en = 1'b0;
    bif.LSB2ARB_en = 1'b0;
  endtask

  task automatic drive_alu(input logic [3:0] t, input logic [31:0] v, input logic [31:0] pc,
                           input int due);
    bif.ALU2ARB_en        = 1'b1;
    bif.ALU2ARB_ROB_index = t;
    bif.ALU2ARB_value     = v;
    bif.ALU2ARB_next_pc   = pc;
    exp_q.push_back('{tag: t, value: v, pc: pc, src: 1'b0, due: due});
  endtask

  task automatic drive_lsb(input logic [3:0] t, input logic [31:0] v, input int due);
    bif.LSB2ARB_en        = 1'b1;
    bif.LSB2ARB_ROB_index = t;
    bif.LSB2ARB_value     = v;
    exp_q.push_back('{tag: t, value: v, pc: 32'h0, src: 1'b1, due: due});
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) step();
    chk(name, exp_q.size(), 0);
    step();
    step();
  endtask

  task automatic do_flush();
    bif.flush_in = 1'b1;
    exp_q.delete();
    step();
    bif.flush_in = 1'b0;
    chk("flush_cdb_en",   bif.CDB_en,       0);
    chk("flush_alu_full", bif.ARB2ALU_full, 0);
    chk("flush_lsb_full", bif.ARB2LSB_full, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : stimulus
    int a_full_seen, l_full_seen, a_acc, l_acc;
    logic        s_en, s_src, s_afull, s_lfull;
    logic [3:0]  s_tag;
    logic [31:0] s_val;

    bif.rdy_in = 1'b1;
    bif.flush_in = 1'b0;
    clear_en();
    bif.ALU2ARB_ROB_index = '0;
    bif.ALU2ARB_value     = '0;
    bif.ALU2ARB_next_pc   = '0;
    bif.LSB2ARB_ROB_index = '0;
    bif.LSB2ARB_value     = '0;

    // Reset state
    #12;
    chk("rst_cdb_en",    bif.CDB_en,        0);
    chk("rst_cdb_tag",   bif.CDB_ROB_index, 0);
    chk("rst_cdb_value", bif.CDB_value,     0);
    chk("rst_cdb_pc",    bif.CDB_next_pc,   0);
    chk("rst_cdb_src",   bif.CDB_src,       0);
    chk("rst_alu_full",  bif.ARB2ALU_full,  0);
    chk("rst_lsb_full",  bif.ARB2LSB_full,  0);
    step();
    rst_n = 1'b1;
    step();

    // Simultaneous push after reset: ALU wins, LSB follows next cycle
    drive_alu(4'd1, 32'h21, 32'h200, cyc + 2);
    drive_lsb(4'd2, 32'h22, cyc + 3);
    step();
    clear_en();
    drain("t2_drain");

    // Single ALU push: pulse exactly one cycle, two edges after the push
    drive_alu(4'd3, 32'h11, 32'h104, cyc + 2);
    step();
    clear_en();
    chk("t1_not_early", bif.CDB_en, 0);
    step();
    step();
    chk("t1_pulse_end", bif.CDB_en, 0);
    drain("t1_drain");

    // Both sources busy for 10 cycles honouring full
    do_flush();
    a_full_seen = 0; l_full_seen = 0; a_acc = 0; l_acc = 0;
    for (int i = 0; i < 10; i++) begin
      clear_en();
      if (bif.ARB2ALU_full) a_full_seen++;
      else begin
        drive_alu(4'(a_acc), 32'h3A00 + a_acc, 32'h3000 + 4 * a_acc, -1);
        a_acc++;
      end
      if (bif.ARB2LSB_full) l_full_seen++;
      else begin
        drive_lsb(4'(8 + l_acc), 32'h3B00 + l_acc, -1);
        l_acc++;
      end
      step();
    end
    clear_en();
    chk("t3_alu_full_cycles", a_full_seen, 4);
    chk("t3_lsb_full_cycles", l_full_seen, 4);
    chk("t3_alu_accepted",    a_acc,       6);
    chk("t3_lsb_accepted",    l_acc,       6);
    drain("t3_drain");

    // LSB fills while ALU keeps the bus busy; third LSB en is refused
    do_flush();
    drive_alu(4'd4, 32'h41, 32'h400, -1);
    drive_lsb(4'd5, 32'h51, -1);
    step();
    drive_alu(4'd6, 32'h42, 32'h404, -1);
    drive_lsb(4'd7, 32'h52, -1);
    step();
    clear_en();
    chk("t4_lsb_full", bif.ARB2LSB_full, 1);
    drive_alu(4'd8, 32'h43, 32'h408, -1);
    bif.LSB2ARB_en        = 1'b1;
    bif.LSB2ARB_ROB_index = 4'hF;
    bif.LSB2ARB_value     = 32'hDEAD;
    step();
    clear_en();
    chk("t4_lsb_full_drop", bif.ARB2LSB_full, 0);
    drain("t4_drain");

    // Flush with pending entries and a live broadcast
    do_flush();
    drive_alu(4'd1, 32'h61, 32'h600, -1);
    drive_lsb(4'd2, 32'h71, -1);
    step();
    drive_alu(4'd3, 32'h62, 32'h604, -1);
    drive_lsb(4'd4, 32'h72, -1);
    step();
    chk("t5_pre_cdb_en",   bif.CDB_en,       1);
    chk("t5_pre_lsb_full", bif.ARB2LSB_full, 1);
    clear_en();
    bif.ALU2ARB_en        = 1'b1;
    bif.ALU2ARB_ROB_index = 4'hE;
    bif.ALU2ARB_value     = 32'hBAD0;
    bif.flush_in = 1'b1;
    exp_q.delete();
    step();
    bif.flush_in = 1'b0;
    clear_en();
    chk("t5_cdb_en",   bif.CDB_en,       0);
    chk("t5_alu_full", bif.ARB2ALU_full, 0);
    chk("t5_lsb_full", bif.ARB2LSB_full, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_quiet", bif.CDB_en, 0);
    end

    // Freeze for 3 cycles mid-stream; pushes during freeze are lost
    drive_alu(4'd9, 32'h81, 32'h800, -1);
    drive_lsb(4'd10, 32'h91, -1);
    step();
    drive_alu(4'd11, 32'h82, 32'h804, -1);
    drive_lsb(4'd12, 32'h92, -1);
    step();
    s_en = bif.CDB_en; s_tag = bif.CDB_ROB_index; s_val = bif.CDB_value; s_src = bif.CDB_src;
    s_afull = bif.ARB2ALU_full; s_lfull = bif.ARB2LSB_full;
    chk("t6_pre_lsb_full", s_lfull, 1);
    bif.rdy_in = 1'b0;
    bif.ALU2ARB_en        = 1'b1;
    bif.ALU2ARB_ROB_index = 4'hD;
    bif.ALU2ARB_value     = 32'hBAD1;
    bif.LSB2ARB_en        = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t6_frozen_en",    bif.CDB_en,        s_en);
      chk("t6_frozen_tag",   bif.CDB_ROB_index, s_tag);
      chk("t6_frozen_value", bif.CDB_value,     s_val);
      chk("t6_frozen_src",   bif.CDB_src,       s_src);
      chk("t6_frozen_afull", bif.ARB2ALU_full,  s_afull);
      chk("t6_frozen_lfull", bif.ARB2LSB_full,  s_lfull);
    end
    bif.rdy_in = 1'b1;
    clear_en();
    drain("t6_drain");

    // Async reset in the middle of a cycle with a live broadcast and a full LSB FIFO
    drive_alu(4'd1, 32'hA1, 32'hA00, -1);
    drive_lsb(4'd2, 32'hB1, -1);
    step();
    clear_en();
    bif.LSB2ARB_en        = 1'b1;
    bif.LSB2ARB_ROB_index = 4'd3;
    bif.LSB2ARB_value     = 32'hB2;
    step();
    clear_en();
    chk("t7_pre_cdb_en",   bif.CDB_en,       1);
    chk("t7_pre_lsb_full", bif.ARB2LSB_full, 1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t7_cdb_en",    bif.CDB_en,        0);
    chk("t7_cdb_tag",   bif.CDB_ROB_index, 0);
    chk("t7_cdb_value", bif.CDB_value,     0);
    chk("t7_cdb_pc",    bif.CDB_next_pc,   0);
    chk("t7_lsb_full",  bif.ARB2LSB_full,  0);
    step();
    rst_n = 1'b1;
    step();
    drive_alu(4'd5, 32'hC1, 32'hC00, cyc + 2);
    drive_lsb(4'd6, 32'hD1, cyc + 3);
    step();
    clear_en();
    drain("t7_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
